// File: rtl/ddr5_ca_pkg.sv
// Shared definitions for the DDR5 write-path command/address block:
// command opcodes, mode-register addresses, burst-mode codes and decoder states.
package ddr5_ca_pkg;

    localparam int unsigned CA_W = 14;

    localparam logic [4:0] CMD_MRW = 5'b00101;
    localparam logic [4:0] CMD_WR  = 5'b01101;

    localparam logic [7:0] MRA_BURST = 8'd0;
    localparam logic [7:0] MRA_WPRE  = 8'd8;
    localparam logic [7:0] MRA_CRC   = 8'd50;

    typedef enum logic [1:0] {
        BM_BL16     = 2'b00,
        BM_BC8_OTF  = 2'b01,
        BM_BL32     = 2'b10,
        BM_BL32_OTF = 2'b11
    } burst_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        MRW2,
        SKIP2
    } dec_state_e;

endpackage

// File: rtl/ca_mr_decoder.sv
// Snoops the registered CS_n/CA stream and keeps shadow copies of the
// write-path mode-register fields (burst length, preamble/postamble, CRC).
module ca_mr_decoder
    import ddr5_ca_pkg::*;
#(
    parameter int NUM_RANK = 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [NUM_RANK-1:0] cs_n_i,
    input  logic [12:0]         ca_i,
    output logic [5:0]          burst_length_o,
    output logic [7:0]          pre_pattern_o,
    output logic [2:0]          pre_cycle_o,
    output logic [1:0]          post_cycle_o,
    output logic                crc_en_o
);

    dec_state_e  state_q, state_d;
    burst_mode_e mode_q, mode_d;
    logic [7:0]  mra_q, mra_d;
    logic [5:0]  bl_q, bl_d;
    logic [7:0]  pre_pat_q, pre_pat_d;
    logic [2:0]  pre_cyc_q, pre_cyc_d;
    logic [1:0]  post_cyc_q, post_cyc_d;
    logic        crc_q, crc_d;
    logic        cmd_start;

    assign cmd_start = ~(&cs_n_i);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            mode_q     <= BM_BL16;
            mra_q      <= '0;
            bl_q       <= 6'd16;
            pre_pat_q  <= 8'b00000010;
            pre_cyc_q  <= 3'd2;
            post_cyc_q <= 2'd1;
            crc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            mra_q      <= mra_d;
            bl_q       <= bl_d;
            pre_pat_q  <= pre_pat_d;
            pre_cyc_q  <= pre_cyc_d;
            post_cyc_q <= post_cyc_d;
            crc_q      <= crc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        mra_d      = mra_q;
        bl_d       = bl_q;
        pre_pat_d  = pre_pat_q;
        pre_cyc_d  = pre_cyc_q;
        post_cyc_d = post_cyc_q;
        crc_d      = crc_q;

        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_start) begin
                        if (ca_i[4:0] == CMD_MRW) begin
                            mra_d   = ca_i[12:5];
                            state_d = MRW2;
                        end else if (ca_i[4:0] == CMD_WR) begin
                            // BL* on the WR first cycle only matters in the on-the-fly modes
                            case (mode_q)
                                BM_BC8_OTF:  bl_d = ca_i[5] ? 6'd16 : 6'd8;
                                BM_BL32_OTF: bl_d = ca_i[5] ? 6'd32 : 6'd16;
                                default:     bl_d = bl_q;
                            endcase
                            state_d = SKIP2;
                        end else if (!ca_i[1]) begin
                            state_d = SKIP2;
                        end
                    end
                end
                MRW2: begin
                    state_d = IDLE;
                    case (mra_q)
                        MRA_BURST: begin
                            mode_d = burst_mode_e'(ca_i[1:0]);
                            bl_d   = ca_i[1] ? 6'd32 : 6'd16;
                        end
                        MRA_WPRE: begin
                            case (ca_i[4:3])
                                2'b01: begin pre_pat_d = 8'b00000010; pre_cyc_d = 3'd2; end
                                2'b10: begin pre_pat_d = 8'b00000100; pre_cyc_d = 3'd3; end
                                2'b11: begin pre_pat_d = 8'b00001010; pre_cyc_d = 3'd4; end
                                default: ;
                            endcase
                            post_cyc_d = ca_i[7] ? 2'd2 : 2'd1;
                        end
                        MRA_CRC: crc_d = ca_i[1];
                        default: ;
                    endcase
                end
                SKIP2:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign burst_length_o = bl_q;
    assign pre_pattern_o  = pre_pat_q;
    assign pre_cycle_o    = pre_cyc_q;
    assign post_cycle_o   = post_cyc_q;
    assign crc_en_o       = crc_q;

endmodule

// File: rtl/command_address.sv
// DDR5 PHY write-path command/address block: registers DFI CA/CS_n onto the
// DRAM pins and feeds the registered bus to the mode-register shadow decoder.
module command_address
    import ddr5_ca_pkg::*;
#(
    parameter int NUM_RANK = 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [CA_W-1:0]     dfi_address,
    input  logic [NUM_RANK-1:0] dfi_cs_n,
    output logic [NUM_RANK-1:0] CS_n,
    output logic [CA_W-1:0]     CA,
    output logic [5:0]          burst_length,
    output logic [7:0]          pre_pattern,
    output logic [2:0]          pre_cycle,
    output logic [1:0]          post_cycle,
    output logic                DRAM_CRC_en
);

    logic [NUM_RANK-1:0] cs_n_q;
    logic [CA_W-1:0]     ca_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cs_n_q <= '1;
            ca_q   <= '0;
        end else if (i_enable) begin
            cs_n_q <= dfi_cs_n;
            ca_q   <= dfi_address;
        end else begin
            cs_n_q <= '1;
            ca_q   <= '0;
        end
    end

    assign CS_n = cs_n_q;
    assign CA   = ca_q;

    ca_mr_decoder #(
        .NUM_RANK(NUM_RANK)
    ) u_dec (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .cs_n_i         (cs_n_q),
        .ca_i           (ca_q[12:0]),
        .burst_length_o (burst_length),
        .pre_pattern_o  (pre_pattern),
        .pre_cycle_o    (pre_cycle),
        .post_cycle_o   (post_cycle),
        .crc_en_o       (DRAM_CRC_en)
    );

endmodule

// File: tb/tb_command_address.sv
// Bench for command_address: directed mode-register scenarios followed by
// random DFI traffic, all checked against a command-level reference model.
module tb_command_address;

    localparam int NR = 1;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [13:0]   dfi_address;
    logic [NR-1:0] dfi_cs_n;
    logic [NR-1:0] CS_n;
    logic [13:0]   CA;
    logic [5:0]    burst_length;
    logic [7:0]    pre_pattern;
    logic [2:0]    pre_cycle;
    logic [1:0]    post_cycle;
    logic          DRAM_CRC_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    command_address #(.NUM_RANK(NR)) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .dfi_address  (dfi_address),
        .dfi_cs_n     (dfi_cs_n),
        .CS_n         (CS_n),
        .CA           (CA),
        .burst_length (burst_length),
        .pre_pattern  (pre_pattern),
        .pre_cycle    (pre_cycle),
        .post_cycle   (post_cycle),
        .DRAM_CRC_en  (DRAM_CRC_en)
    );

    // Reference model: pin values one cycle behind DFI, plus command-level
    // bookkeeping of whether the next registered word is a second cycle.
    int  m_cs, m_ca;
    bit  m_second, m_is_mrw;
    int  m_mra, m_mode, m_bl, m_pre_pat, m_pre_cyc, m_post, m_crc;
    int  pre_tbl [4] = '{0, 2, 4, 10};

    task automatic model_reset();
        m_cs = (1 << NR) - 1; m_ca = 0;
        m_second = 0; m_is_mrw = 0; m_mra = 0;
        m_mode = 0; m_bl = 16; m_pre_pat = 2; m_pre_cyc = 2; m_post = 1; m_crc = 0;
    endtask

    task automatic model_mrw(input int mra, input int op);
        int wpre;
        if (mra == 0) begin
            m_mode = op % 4;
            m_bl   = ((op / 2) % 2 == 1) ? 32 : 16;
        end else if (mra == 8) begin
            wpre = (op / 8) % 4;
            if (wpre != 0) begin
                m_pre_cyc = wpre + 1;
                m_pre_pat = pre_tbl[wpre];
            end
            m_post = (op / 128) % 2 + 1;
        end else if (mra == 50) begin
            m_crc = (op / 2) % 2;
        end
    endtask

    task automatic model_edge(input bit en, input int cs, input int addr);
        int opc;
        if (!en) begin
            m_second = 0;
        end else if (m_second) begin
            if (m_is_mrw) model_mrw(m_mra, m_ca % 256);
            m_second = 0;
        end else if (m_cs != (1 << NR) - 1) begin
            opc = m_ca % 32;
            if (opc == 5) begin
                m_second = 1; m_is_mrw = 1; m_mra = (m_ca / 32) % 256;
            end else if (opc == 13) begin
                if (m_mode == 1 || m_mode == 3)
                    m_bl = ((m_mode == 1) ? 8 : 16) * (((m_ca / 32) % 2) + 1);
                m_second = 1; m_is_mrw = 0;
            end else if ((m_ca / 2) % 2 == 0) begin
                m_second = 1; m_is_mrw = 0;
            end
        end
        m_cs = en ? cs : (1 << NR) - 1;
        m_ca = en ? addr : 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".CS_n"},         32'(CS_n),         32'(m_cs));
        check({tag, ".CA"},           32'(CA),           32'(m_ca));
        check({tag, ".burst_length"}, 32'(burst_length), 32'(m_bl));
        check({tag, ".pre_pattern"},  32'(pre_pattern),  32'(m_pre_pat));
        check({tag, ".pre_cycle"},    32'(pre_cycle),    32'(m_pre_cyc));
        check({tag, ".post_cycle"},   32'(post_cycle),   32'(m_post));
        check({tag, ".crc"},          32'(DRAM_CRC_en),  32'(m_crc));
    endtask

    // Called at a negedge: drive, let one rising edge pass, check at next negedge.
    task automatic step(input string tag, input bit en, input logic [NR-1:0] cs, input logic [13:0] a);
        i_enable = en; dfi_cs_n = cs; dfi_address = a;
        @(posedge clk);
        model_edge(en, int'(cs), int'(a));
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, '1, 14'd0);
    endtask

    initial begin
        logic [13:0]   a;
        logic [NR-1:0] cs;
        bit            en;
        int            k;

        i_reset = 1'b0; i_enable = 1'b1; dfi_cs_n = '0; dfi_address = 14'b00000000000101;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        i_reset = 1'b1;
        idle("post_reset");

        // WR passthrough, BL16 mode leaves burst length alone
        step("wr0", 1'b1, '0, 14'b10100000001101);
        check("wr0.CA_direct", 32'(CA), 32'(14'b10100000001101));
        step("wr1", 1'b1, '1, 14'b11010000001101);
        check("wr1.CA_direct", 32'(CA), 32'(14'b11010000001101));
        check("wr1.CS_direct", 32'(CS_n), 32'({NR{1'b1}}));
        idle("wr2");
        check("wr.bl16", 32'(burst_length), 32'd16);

        // MR8: preamble 11, postamble 1.5 tCK
        step("mr8a", 1'b1, '0, 14'b00000100000101);
        step("mr8b", 1'b1, '1, 14'b00000010011000);
        idle("mr8c");
        check("mr8.pat", 32'(pre_pattern), 32'b00001010);
        check("mr8.cyc", 32'(pre_cycle), 32'd4);
        check("mr8.post", 32'(post_cycle), 32'd2);

        // MR50: CRC enable
        step("mr50a", 1'b1, '0, 14'b00011001000101);
        step("mr50b", 1'b1, '1, 14'b00000000000110);
        idle("mr50c");
        check("mr50.crc", 32'(DRAM_CRC_en), 32'd1);

        // MR0: BL32 OTF, then WR BL* selects 16 / 32
        step("mr0a", 1'b1, '0, 14'b00000000000101);
        step("mr0b", 1'b1, '1, 14'b00000000000011);
        idle("mr0c");
        check("mr0.bl32", 32'(burst_length), 32'd32);
        step("wrbl_a", 1'b1, '0, 14'b00000000001101);
        idle("wrbl_b");
        idle("wrbl_c");
        check("wrbl.bl16", 32'(burst_length), 32'd16);
        step("wrbl_d", 1'b1, '0, 14'b00000000101101);
        idle("wrbl_e");
        idle("wrbl_f");
        check("wrbl.bl32", 32'(burst_length), 32'd32);

        // Enable dropped during MRW second cycle: pins idle, fields untouched
        step("en_a", 1'b1, '0, 14'b00000100000101);
        step("en_b", 1'b0, '0, 14'b00000000001000);
        check("en.CS", 32'(CS_n), 32'({NR{1'b1}}));
        check("en.CA", 32'(CA), 32'd0);
        idle("en_c");
        idle("en_d");
        check("en.cyc_hold", 32'(pre_cycle), 32'd4);
        check("en.post_hold", 32'(post_cycle), 32'd2);

        // Random traffic with biased MRW/WR commands
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 99) < 94);
            cs = ($urandom_range(0, 9) < 7) ? {NR{1'b0}} : {NR{1'b1}};
            a  = 14'($urandom);
            k  = $urandom_range(0, 9);
            if (k < 4) begin
                a[4:0] = 5'b00101;
                case ($urandom_range(0, 3))
                    0: a[12:5] = 8'd0;
                    1: a[12:5] = 8'd8;
                    2: a[12:5] = 8'd50;
                    default: ;
                endcase
            end else if (k < 6) begin
                a[4:0] = 5'b01101;
            end
            step("rand", en, cs, a);
        end

        // Asynchronous reset mid-command
        step("rst_a", 1'b1, '0, 14'b00000100000101);
        i_enable = 1'b1; dfi_cs_n = '1; dfi_address = 14'b00000000011000;
        #2 i_reset = 1'b0;
        #1 model_reset();
        check_all("rst_async");
        @(negedge clk);
        check_all("rst_hold");
        i_reset = 1'b1;
        idle("rst_b");
        idle("rst_c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
